mem_stage: RTL
==============

# mem_stage

Memory (MEM) stage of the SCHOLAR RISC-V core, between Execute (EXE) and Writeback (WB). It holds the EXE->MEM pipeline register and issues load/store requests on the data-memory port. It stalls EXE while a request waits for grant, and presents a `mem2wb_t` payload plus `mem_valid_o` to WB. WB samples `d_m_rdata_i` combinationally in the cycle after `mem_valid_o`.

## Interface
- DATA_WIDTH, `core_pkg::DATA_WIDTH` (32): data path and store data width.
- ADDR_WIDTH, 32: data-memory byte address width.

- clk_i  in  1  system clock.
- rstn_i  in  1  system reset; synchronous, active-low.
- exe_valid_i  in  1  EXE presents a valid uop.
- exe2mem_i  in  `exe2mem_t`  fields: `exe_out` (address/result), `op3` (store data), `rd`, `csr_waddr`, `gpr_ctrl`, `csr_ctrl`, `mem_ctrl`.
- exe_ready_o  out  1  MEM accepts a uop this cycle.
- mem_valid_o  out  1  uop completes MEM this cycle; drives WB `mem_valid_i`.
- mem2wb_o  out  `mem2wb_t`  registered payload to WB.
- d_m_req_o  out  1  data-memory request.
- d_m_we_o  out  1  1: store, 0: load.
- d_m_addr_o  out  ADDR_WIDTH  word-aligned address, i.e. `{exe_out[31:2],2'b00}`.
- d_m_be_o  out  4  store byte enables; 0 for loads.
- d_m_wdata_o  out  DATA_WIDTH  lane-replicated store data.
- d_m_gnt_i  in  1  request accepted this cycle.
- misaligned_o  out  1  one-cycle pulse for a misaligned access.

## Operation
- Pipeline register: `valid_q` and `payload_q`. Capture on the rising edge when `exe_valid_i && exe_ready_o`.
  - If `exe_ready_o` is high and `exe_valid_i` is low, `valid_q` is cleared.
- Rule: `is_mem = valid_q && mem_ctrl_q != MEM_IDLE`.
- Rule: `done = valid_q && (!is_mem || d_m_gnt_i || misaligned)`.
- Handshakes: `exe_ready_o = !valid_q || done`. `mem_valid_o = done`.
- FSM states:
  - IDLE: no memory uop pending.
  - REQ: memory uop presented and not yet granted.
- FSM transitions:
  - IDLE->REQ when a load/store is captured and is aligned.
  - REQ->REQ while `!d_m_gnt_i`.
  - REQ->IDLE on grant when no new memory uop is captured the same edge.
  - REQ->REQ on grant when a new memory uop is captured the same edge (back-to-back).
- `d_m_req_o` equals `state==REQ`. While REQ, `addr/we/be/wdata` are stable (driven from `payload_q`) until `d_m_gnt_i`.
- Store lanes, with `a = exe_out[1:0]`:
  - SB: `be = 4'b0001<<a`, `wdata = {4{op3[7:0]}}`.
  - SH: `be = 4'b0011<<a`, `wdata = {2{op3[15:0]}}`.
  - SW: `be = 4'b1111`, `wdata = op3`.
- Loads: `be = 0`. Sign/zero extraction is done downstream using `exe_out[1:0]`; `mem2wb_o.exe_out` keeps the full byte address.
- Misalignment means a halfword with `a[0]=1`, or a word with `a!=0`.
  - No request is issued; the stage goes straight to done.
  - `misaligned_o` pulses for the cycle `mem_valid_o` is high.
  - `mem2wb_o.gpr_ctrl` is forced to `GPR_IDLE` and `csr_ctrl` to `CSR_IDLE` for that uop.
- `mem2wb_o` is `payload_q` with the forcing above. It is meaningful only when `mem_valid_o` is high.

## Timing
- Reset: on the edge with `rstn_i=0`, `valid_q=0`, state=IDLE, `payload_q='0`. Consequently `exe_ready_o=1`, `mem_valid_o=0`, `d_m_req_o=0`, `d_m_we_o=0`, `d_m_be_o=0`, `d_m_addr_o=0`, `d_m_wdata_o=0`, `misaligned_o=0`, `mem2wb_o='0`.
- Reset mid-request drops `d_m_req_o` the following cycle. A grant seen in the reset cycle is ignored; no `mem_valid_o`.
- Non-memory uop: captured at edge N; `mem_valid_o=1` during cycle N+1. Throughput is 1 uop/cycle.
- Load/store with immediate grant: `d_m_req_o` and `d_m_gnt_i` are both high in cycle N+1, so `mem_valid_o=1` in N+1.
- Memory rdata for a granted load is valid in cycle N+2, the WB cycle.
- Grant delayed k cycles: `mem_valid_o` and `exe_ready_o` stay low for k cycles. The next uop is accepted on the grant edge.
- Simultaneous grant and new `exe_valid_i`: the uop is completed and the new uop is captured on the same edge, with no bubble.
- `exe_valid_i` low while `exe_ready_o` high: a bubble; `mem_valid_o` is low next cycle.

## Test plan
- Reset: hold `rstn_i=0` for 2 cycles with `exe_valid_i=1` -> all outputs 0 and `exe_ready_o=1`; no capture.
- ALU stream: 4 back-to-back non-memory uops with rd=1..4 -> `mem_valid_o` is high for 4 consecutive cycles with rd 1,2,3,4 in order, and `d_m_req_o` stays 0.
- SB to 0x1003 with `op3=0xA5`, `gnt=1` -> `d_m_addr_o=0x1000`, `be=4'b1000`, `wdata=0xA5A5A5A5`, `we=1`; `mem_valid_o` in the same cycle.
- LW to 0x2000 with `gnt` delayed 3 cycles -> `d_m_req_o` high for 4 cycles with stable address; `exe_ready_o=0` for 3 cycles; `mem_valid_o` is a single pulse on the grant cycle.
- SH to 0x3001 -> no `d_m_req_o`; `misaligned_o=1` and `mem_valid_o=1` for one cycle with `gpr_ctrl=GPR_IDLE`.
- Reset asserted in the second wait cycle of a pending LW -> `d_m_req_o=0` the next cycle, and no `mem_valid_o` pulse after reset.

Source files
------------

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - SCHOLAR RISC-V memory stage: EXE->MEM register, data-memory request FSM, WB payload
package core_pkg;
    localparam int DATA_WIDTH = 32;

    localparam logic [3:0] MEM_IDLE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    localparam logic [1:0] GPR_IDLE = 2'd0;
    localparam logic [1:0] GPR_ALU  = 2'd1;
    localparam logic [1:0] GPR_MEM  = 2'd2;

    localparam logic [1:0] CSR_IDLE = 2'd0;
    localparam logic [1:0] CSR_WR   = 2'd1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] exe_out;
        logic [DATA_WIDTH-1:0] op3;
        logic [4:0]            rd;
        logic [11:0]           csr_waddr;
        logic [1:0]            gpr_ctrl;
        logic [1:0]            csr_ctrl;
        logic [3:0]            mem_ctrl;
    } exe2mem_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] exe_out;
        logic [4:0]            rd;
        logic [11:0]           csr_waddr;
        logic [1:0]            gpr_ctrl;
        logic [1:0]            csr_ctrl;
        logic [3:0]            mem_ctrl;
    } mem2wb_t;
endpackage

module mem_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  exe_valid_i,
    input  exe2mem_t              exe2mem_i,
    output logic                  exe_ready_o,
    output logic                  mem_valid_o,
    output mem2wb_t               mem2wb_o,
    output logic                  d_m_req_o,
    output logic                  d_m_we_o,
    output logic [ADDR_WIDTH-1:0] d_m_addr_o,
    output logic [3:0]            d_m_be_o,
    output logic [DATA_WIDTH-1:0] d_m_wdata_o,
    input  logic                  d_m_gnt_i,
    output logic                  misaligned_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic       valid_q, valid_d;
    exe2mem_t   payload_q, payload_d;
    logic [0:0] state_q, state_d;

    logic       is_mem, misaligned, done, capture, new_req;
    logic [3:0] be_w;
    logic [DATA_WIDTH-1:0] wdata_w;

    function automatic logic misaligned_f(input logic [3:0] ctrl, input logic [1:0] a);
        case (ctrl)
            MEM_LH, MEM_LHU, MEM_SH: misaligned_f = a[0];
            MEM_LW, MEM_SW:          misaligned_f = (a != 2'b00);
            default:                 misaligned_f = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_f(input logic [3:0] ctrl);
        is_store_f = (ctrl == MEM_SB) || (ctrl == MEM_SH) || (ctrl == MEM_SW);
    endfunction

    assign is_mem     = valid_q && (payload_q.mem_ctrl != MEM_IDLE);
    assign misaligned = is_mem && misaligned_f(payload_q.mem_ctrl, payload_q.exe_out[1:0]);
    // A grant arriving while reset is asserted must not complete the uop.
    assign done       = rstn_i && valid_q && (!is_mem || d_m_gnt_i || misaligned);

    assign exe_ready_o  = !valid_q || done;
    assign mem_valid_o  = done;
    assign misaligned_o = done && misaligned;
    assign capture      = exe_valid_i && exe_ready_o;
    assign new_req      = (exe2mem_i.mem_ctrl != MEM_IDLE)
                          && !misaligned_f(exe2mem_i.mem_ctrl, exe2mem_i.exe_out[1:0]);

    always_comb begin
        valid_d   = exe_ready_o ? exe_valid_i : valid_q;
        payload_d = capture ? exe2mem_i : payload_q;
        if (capture) begin
            state_d = new_req ? S_REQ : S_IDLE;
        end else if (done) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            state_q   <= S_IDLE;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        be_w    = 4'b0000;
        wdata_w = '0;
        case (payload_q.mem_ctrl)
            MEM_SB: begin
                be_w    = 4'b0001 << payload_q.exe_out[1:0];
                wdata_w = {4{payload_q.op3[7:0]}};
            end
            MEM_SH: begin
                be_w    = 4'b0011 << payload_q.exe_out[1:0];
                wdata_w = {2{payload_q.op3[15:0]}};
            end
            MEM_SW: begin
                be_w    = 4'b1111;
                wdata_w = payload_q.op3;
            end
            default: begin
                be_w    = 4'b0000;
                wdata_w = '0;
            end
        endcase
    end

    // Bus fields are held at zero outside REQ so idle cycles carry no stale data.
    assign d_m_req_o   = (state_q == S_REQ);
    assign d_m_we_o    = d_m_req_o && is_store_f(payload_q.mem_ctrl);
    assign d_m_addr_o  = d_m_req_o ? {payload_q.exe_out[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign d_m_be_o    = d_m_req_o ? be_w : 4'b0000;
    assign d_m_wdata_o = d_m_req_o ? wdata_w : '0;

    always_comb begin
        mem2wb_o.exe_out   = payload_q.exe_out;
        mem2wb_o.rd        = payload_q.rd;
        mem2wb_o.csr_waddr = payload_q.csr_waddr;
        mem2wb_o.mem_ctrl  = payload_q.mem_ctrl;
        mem2wb_o.gpr_ctrl  = misaligned ? GPR_IDLE : payload_q.gpr_ctrl;
        mem2wb_o.csr_ctrl  = misaligned ? CSR_IDLE : payload_q.csr_ctrl;
    end

endmodule
